fifo_spram_wide_fwft: RTL and testbench

- Parametrised successor to the single-port-RAM FWFT sync FIFO.
- Sustains one write and one read every cycle using a single-port RAM of double word width (FIFO_DEPTH/2 entries × 2*DATA_WIDTH), instead of stalling on read/write collisions.
- Adds programmable almost-full/almost-empty flags, an occupancy count, a synchronous flush and overflow/underflow error pulses.
- Sits between streaming producers and consumers wherever a dual-port RAM is too costly.

---
 rtl/fifo_spram_wide_fwft.sv | 194 +++++++++++++++++++
 tb/tb_fifo_spram_wide_fwft.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_spram_wide_fwft.sv
// First-word-fall-through sync FIFO on a single-port RAM of double word width.
// Writes are gathered into pairs; pairs are read back into a 4-word output buffer (OB).
module fifo_spram_wide_fwft #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_TH      = FIFO_DEPTH - 2,
   parameter int AE_TH      = 2,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  full_o,
   output logic                  almost_full_o,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);
   localparam int W     = DATA_WIDTH;
   localparam int PAIRS = FIFO_DEPTH / 2;
   localparam int AW    = $clog2(PAIRS);
   localparam int PW    = AW + 1;

   logic [CNT_W-1:0] r_count;
   logic             r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
   logic [PW-1:0]    r_wptr, r_rptr;
   logic             r_inf;
   logic [1:0]       r_g_cnt;
   logic [W-1:0]     r_g [2];
   logic [W-1:0]     r_ob [4];
   logic [1:0]       r_ob_rd;
   logic [2:0]       r_ob_cnt;
   logic [2*W-1:0]   r_mem [PAIRS];
   logic [2*W-1:0]   r_ram_q;

   logic             w_wacc, w_racc, w_ram_empty, w_path_clr, w_g_full;
   logic             w_pair_mv, w_ram_we, w_ram_re, w_lone, w_byp;
   logic             w_pop_ob, w_pop_q, w_g_out, w_g_in;
   logic [1:0]       w_g_keep, w_push_n, w_ob_wr0, w_ob_wr1;
   logic [W-1:0]     w_push0, w_push1;
   logic [PW-1:0]    w_ram_cnt;
   logic [CNT_W-1:0] w_count_d;

   assign w_wacc      = wen & ~r_full;
   assign w_racc      = ren & ~r_empty;
   assign w_count_d   = clr ? '0 : r_count + CNT_W'(w_wacc) - CNT_W'(w_racc);
   assign w_ram_cnt   = r_wptr - r_rptr;
   assign w_ram_empty = (r_wptr == r_rptr);
   assign w_path_clr  = w_ram_empty & ~r_inf;
   assign w_g_full    = (r_g_cnt == 2'd2);

   // A full gather always leaves this cycle: straight into OB when nothing older is
   // queued behind the RAM, otherwise as one RAM pair write (which outranks a read).
   assign w_pair_mv = w_g_full & w_path_clr & (r_ob_cnt <= 3'd2);
   assign w_ram_we  = w_g_full & ~w_pair_mv;
   assign w_ram_re  = ~w_g_full & ~w_ram_empty & ((r_ob_cnt + {1'b0, r_inf, 1'b0}) <= 3'd2);
   assign w_lone    = (r_g_cnt == 2'd1) & w_path_clr & (r_ob_cnt != 3'd4);
   assign w_byp     = w_wacc & (r_g_cnt == 2'd0) & w_path_clr & (r_ob_cnt != 3'd4);

   // With OB empty the in-flight pair is the head, so its low word is shown and popped directly.
   assign w_pop_ob  = w_racc & (r_ob_cnt != 3'd0);
   assign w_pop_q   = w_racc & (r_ob_cnt == 3'd0);
   assign rdata     = (r_ob_cnt == 3'd0 && r_inf) ? r_ram_q[W-1:0] : r_ob[r_ob_rd];

   assign w_g_out   = w_g_full | w_lone;
   assign w_g_keep  = w_g_out ? 2'd0 : r_g_cnt;
   assign w_g_in    = w_wacc & ~w_byp;
   assign w_ob_wr0  = r_ob_rd + r_ob_cnt[1:0];
   assign w_ob_wr1  = w_ob_wr0 + 2'd1;

   always_comb begin
      w_push_n = 2'd0;
      w_push0  = '0;
      w_push1  = '0;
      if (r_inf) begin
         if (w_pop_q) begin
            w_push_n = 2'd1;
            w_push0  = r_ram_q[2*W-1:W];
         end else begin
            w_push_n = 2'd2;
            w_push0  = r_ram_q[W-1:0];
            w_push1  = r_ram_q[2*W-1:W];
         end
      end else if (w_pair_mv) begin
         w_push_n = 2'd2;
         w_push0  = r_g[0];
         w_push1  = r_g[1];
      end else if (w_lone) begin
         w_push_n = 2'd1;
         w_push0  = r_g[0];
      end else if (w_byp) begin
         w_push_n = 2'd1;
         w_push0  = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_mem[r_wptr[AW-1:0]] <= {r_g[1], r_g[0]};
      else if (w_ram_re)
         r_ram_q <= r_mem[r_rptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (w_g_in)
         r_g[w_g_keep[0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ob <= '{default: '0};
      end else if (clr) begin
         r_ob <= '{default: '0};
      end else begin
         if (w_push_n != 2'd0)
            r_ob[w_ob_wr0] <= w_push0;
         if (w_push_n == 2'd2)
            r_ob[w_ob_wr1] <= w_push1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_inf    <= 1'b0;
         r_g_cnt  <= 2'd0;
         r_ob_rd  <= 2'd0;
         r_ob_cnt <= 3'd0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (clr) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_inf    <= 1'b0;
         r_g_cnt  <= 2'd0;
         r_ob_rd  <= 2'd0;
         r_ob_cnt <= 3'd0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_ram_we) r_wptr <= r_wptr + PW'(1);
         if (w_ram_re) r_rptr <= r_rptr + PW'(1);
         r_inf    <= w_ram_re;
         r_g_cnt  <= w_g_keep + {1'b0, w_g_in};
         r_ob_rd  <= r_ob_rd + {1'b0, w_pop_ob};
         r_ob_cnt <= r_ob_cnt - {2'b00, w_pop_ob} + {1'b0, w_push_n};
         r_ovf    <= wen & r_full;
         r_udf    <= ren & r_empty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
      end else begin
         r_count  <= w_count_d;
         r_full   <= (w_count_d == CNT_W'(FIFO_DEPTH));
         r_afull  <= (w_count_d >= CNT_W'(AF_TH));
         r_empty  <= (w_count_d == '0);
         r_aempty <= (w_count_d <= CNT_W'(AE_TH));
      end
   end

   assign count_o        = r_count;
   assign full_o         = r_full;
   assign almost_full_o  = r_afull;
   assign empty_o        = r_empty;
   assign almost_empty_o = r_aempty;
   assign overflow_o     = r_ovf;
   assign underflow_o    = r_udf;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (r_count <= CNT_W'(FIFO_DEPTH));
         assert (!(r_full && r_empty));
         assert (!(w_ram_we && w_ram_cnt == PW'(PAIRS)));
         assert (r_ob_cnt <= 3'd4);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_spram_wide_fwft.sv
// Directed vector table plus scoreboard-checked sequences for fifo_spram_wide_fwft.
module tb_fifo_spram_wide_fwft;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0, wen = 1'b0, ren = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          full_o, almost_full_o, empty_o, almost_empty_o, overflow_o, underflow_o;
   logic [DW-1:0] rdata;
   logic [CW-1:0] count_o;

   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] q[$];

   fifo_spram_wide_fwft #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .wdata(wdata),
      .full_o(full_o), .almost_full_o(almost_full_o), .ren(ren), .rdata(rdata),
      .empty_o(empty_o), .almost_empty_o(almost_empty_o), .count_o(count_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          c, w, r;
      logic [DW-1:0] d;
      int            cnt;
      logic          emp, ae, ovf, udf, chk_rd;
      logic [DW-1:0] rd;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 25)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive, step past the edge, update the reference queue and compare everything.
   task automatic cycle(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      bit m_full, m_empty, e_ovf, e_udf;
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      e_ovf   = !c && w && m_full;
      e_udf   = !c && r && m_empty;
      clr = c; wen = w; ren = r; wdata = d;
      @(posedge clk);
      #1;
      if (c) q.delete();
      else begin
         if (r && !m_empty) void'(q.pop_front());
         if (w && !m_full) q.push_back(d);
      end
      chk("count", int'(count_o), q.size());
      chk("empty", int'(empty_o), int'(q.size() == 0));
      chk("full", int'(full_o), int'(q.size() == DEPTH));
      chk("almost_empty", int'(almost_empty_o), int'(q.size() <= 2));
      chk("almost_full", int'(almost_full_o), int'(q.size() >= DEPTH - 2));
      chk("overflow", int'(overflow_o), int'(e_ovf));
      chk("underflow", int'(underflow_o), int'(e_udf));
      if (q.size() > 0) chk("rdata", int'(rdata), int'(q[0]));
   endtask

   initial begin
      //        c  w  r  d      cnt emp ae ovf udf chk rd
      tbl[0]  = '{0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00};
      tbl[1]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 1, 0, 8'h00};
      tbl[2]  = '{0, 1, 0, 8'h5A, 1, 0, 1, 0, 0, 1, 8'h5A};
      tbl[3]  = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00};
      tbl[4]  = '{0, 1, 0, 8'h11, 1, 0, 1, 0, 0, 1, 8'h11};
      tbl[5]  = '{0, 1, 1, 8'h22, 1, 0, 1, 0, 0, 1, 8'h22};
      tbl[6]  = '{0, 1, 0, 8'h33, 2, 0, 1, 0, 0, 1, 8'h22};
      tbl[7]  = '{0, 1, 0, 8'h44, 3, 0, 0, 0, 0, 1, 8'h22};
      tbl[8]  = '{0, 1, 0, 8'h55, 4, 0, 0, 0, 0, 1, 8'h22};
      tbl[9]  = '{0, 1, 0, 8'h66, 5, 0, 0, 0, 0, 1, 8'h22};
      tbl[10] = '{1, 1, 1, 8'h99, 0, 1, 1, 0, 0, 0, 8'h00};
      tbl[11] = '{0, 1, 0, 8'h33, 1, 0, 1, 0, 0, 1, 8'h33};
      tbl[12] = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h33};
      tbl[13] = '{0, 0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", int'(count_o), 0);
      chk("rst_empty", int'(empty_o), 1);
      chk("rst_aempty", int'(almost_empty_o), 1);
      chk("rst_full", int'(full_o), 0);
      chk("rst_afull", int'(almost_full_o), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      chk("rst_udf", int'(underflow_o), 0);
      chk("rst_rdata", int'(rdata), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: single-word latency, pass-through, flush with wen/ren
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
         chk($sformatf("vec%0d_count", i), int'(count_o), tbl[i].cnt);
         chk($sformatf("vec%0d_empty", i), int'(empty_o), int'(tbl[i].emp));
         chk($sformatf("vec%0d_aempty", i), int'(almost_empty_o), int'(tbl[i].ae));
         chk($sformatf("vec%0d_ovf", i), int'(overflow_o), int'(tbl[i].ovf));
         chk($sformatf("vec%0d_udf", i), int'(underflow_o), int'(tbl[i].udf));
         if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), int'(rdata), int'(tbl[i].rd));
      end

      // Fill to full, then one dropped write
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(0, 1, 0, 8'(i));
         chk("fill_count", int'(count_o), i);
         chk("fill_full", int'(full_o), int'(i == DEPTH));
         chk("fill_afull", int'(almost_full_o), int'(i >= DEPTH - 2));
         chk("fill_head", int'(rdata), 1);
      end
      cycle(0, 1, 0, 8'hAA);
      chk("drop_ovf", int'(overflow_o), 1);
      chk("drop_count", int'(count_o), DEPTH);
      cycle(0, 0, 0, 8'h00);
      chk("ovf_once", int'(overflow_o), 0);

      // Drain in order, then one read too many
      for (int k = 1; k <= DEPTH; k++) begin
         cycle(0, 0, 1, 8'h00);
         chk("drain_count", int'(count_o), DEPTH - k);
         if (k < DEPTH) chk("drain_rdata", int'(rdata), k + 1);
         chk("drain_aempty", int'(almost_empty_o), int'(DEPTH - k <= 2));
         chk("drain_empty", int'(empty_o), int'(k == DEPTH));
      end
      cycle(0, 0, 1, 8'h00);
      chk("extra_udf", int'(underflow_o), 1);
      chk("extra_count", int'(count_o), 0);

      // Preload 8, then simultaneous read/write across several pointer wraps
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'(8'h80 + i));
      for (int i = 0; i < 200; i++) begin
         cycle(0, 1, 1, 8'(i));
         chk("sustain_count", int'(count_o), 8);
      end
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 8'h00);
      chk("sustain_drained", int'(empty_o), 1);

      // Random traffic in three mixes
      for (int ph = 0; ph < 3; ph++) begin
         int pw, pr;
         pw = (ph == 0) ? 50 : (ph == 1) ? 90 : 30;
         pr = (ph == 0) ? 50 : (ph == 1) ? 30 : 90;
         for (int i = 0; i < 3334; i++)
            cycle(0, ($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom));
      end

      // Asynchronous reset with content held
      cycle(0, 1, 0, 8'hC3);
      cycle(0, 1, 0, 8'hC4);
      rst_n = 1'b0;
      #2;
      q.delete();
      chk("mid_rst_count", int'(count_o), 0);
      chk("mid_rst_empty", int'(empty_o), 1);
      chk("mid_rst_full", int'(full_o), 0);
      chk("mid_rst_rdata", int'(rdata), 0);
      clr = 1'b0; wen = 1'b0; ren = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(0, 1, 0, 8'h7E);
      chk("post_rst_rdata", int'(rdata), 8'h7E);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
